// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared constants for the BCD conversion scheduler:
// FSM encodings, default widths and double-dabble digit adjust values.
package bcd_conv_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam int DEF_IN_W   = 16;
   localparam int DEF_DIGITS = 8;

   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_CORR   = 4'd3;

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Requester-side bus of the BCD conversion scheduler:
// per-requester req/operand/ack plus the shared result channel.
interface bcd_conv_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 16,
   parameter int DIGITS  = 8,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]      req;
   logic [NUM_REQ*IN_W-1:0] req_data;
   logic [NUM_REQ-1:0]      ack;
   logic                    busy;
   logic                    done;
   logic [ID_W-1:0]         done_id;
   logic [4*DIGITS-1:0]     dec_out;

   modport master (
      output req, req_data,
      input  ack, busy, done, done_id, dec_out
   );

   modport slave (
      input  req, req_data,
      output ack, busy, done, done_id, dec_out
   );
endinterface

// File: rtl/bcd_dabble_core.sv
// Serial shift-and-add-3 binary to BCD engine, one operand bit per
// cycle MSB first; the operand is latched on start.
module bcd_dabble_core
   import bcd_conv_scheduler_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  running,
   output logic                  finished,
   output logic [4*DIGITS-1:0]   bcd_out
);
   localparam int SR_W  = 4 * DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IN_W - 1);

   logic [IN_W-1:0]  op_q, op_d;
   logic [SR_W-1:0]  sr_q, sr_d, adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   always_comb begin
      adj   = sr_q;
      op_d  = op_q;
      sr_d  = sr_q;
      cnt_d = cnt_q;
      run_d = run_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_q[4*i +: 4] >= ADJ_THRESH)
            adj[4*i +: 4] = sr_q[4*i +: 4] + ADJ_CORR;
      end
      if (start) begin
         op_d  = bin_in;
         sr_d  = '0;
         cnt_d = CNT_TOP;
         run_d = 1'b1;
      end else if (run_q) begin
         sr_d  = {adj[SR_W-2:0], op_q[cnt_q]};
         run_d = (cnt_q != '0);
         if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= '0;
         sr_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         op_q  <= op_d;
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign running  = run_q;
   assign finished = run_q && (cnt_q == '0);
   assign bcd_out  = sr_q;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one serial BCD engine among
// NUM_REQ requesters; results come back tagged with the requester ID.
module bcd_conv_scheduler
   import bcd_conv_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = DEF_IN_W,
   parameter int DIGITS  = DEF_DIGITS,
   parameter int ID_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   bcd_conv_scheduler_if.slave bus
);
   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                done_q, done_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic [4*DIGITS-1:0] dec_q, dec_d;

   logic                start;
   logic                found;
   logic [ID_W-1:0]     pick;
   logic [IN_W-1:0]     pick_data;
   logic                core_running;
   logic                core_finished;
   logic [4*DIGITS-1:0] core_bcd;
   int                  idx;

   // First requesting index at or after the pointer, wrapping.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
      pick_data = bus.req_data[int'(pick)*IN_W +: IN_W];
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      ack_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      dec_d     = dec_q;
      start     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               start   = 1'b1;
               grant_d = pick;
               ack_d   = NUM_REQ'(1) << pick;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (core_finished)
               state_d = S_DONE;
         end
         S_DONE: begin
            dec_d     = core_bcd;
            done_id_d = grant_q;
            done_d    = 1'b1;
            ptr_d     = (int'(grant_q) == NUM_REQ - 1) ?
                        '0 : grant_q + ID_W'(1);
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         dec_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         dec_q     <= dec_d;
      end
   end

   bcd_dabble_core #(
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin_in   (pick_data),
      .running  (core_running),
      .finished (core_finished),
      .bcd_out  (core_bcd)
   );

   assign bus.ack     = ack_q;
   assign bus.busy    = core_running | (state_q == S_DONE);
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.dec_out = dec_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler: vector table of single
// conversions plus arbitration, reset-abort and busy-drop sequences.
module tb_bcd_conv_scheduler;
   localparam int NUM_REQ = 4;
   localparam int IN_W    = 16;
   localparam int DIGITS  = 8;
   localparam int ID_W    = 2;

   typedef struct {
      int          id;
      logic [15:0] op;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_conv_scheduler_if #(
      .NUM_REQ(NUM_REQ), .IN_W(IN_W), .DIGITS(DIGITS), .ID_W(ID_W)
   ) bus ();

   bcd_conv_scheduler #(
      .NUM_REQ(NUM_REQ), .IN_W(IN_W), .DIGITS(DIGITS), .ID_W(ID_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   int ids[$];
   logic [31:0] vals[$];
   int gaps[$];
   int dbl;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_single(input int id, input logic [15:0] op,
                             input logic [31:0] exp);
      int wait_n;
      int lat;
      int busy_bad;
      wait_n = 0;
      busy_bad = 0;
      bus.req_data[id*IN_W +: IN_W] = op;
      bus.req[id] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         wait_n++;
         if (bus.ack != '0) break;
      end
      chk("ack_onehot", 32'(bus.ack), 32'(1) << id);
      chk("ack_lat", 32'(wait_n), 32'd1);
      if (!bus.busy) busy_bad++;
      bus.req[id] = 1'b0;
      bus.req_data[id*IN_W +: IN_W] = ~op;
      lat = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         lat++;
         if (bus.done) break;
         if (!bus.busy) busy_bad++;
      end
      chk("ack_to_done", 32'(lat), 32'd17);
      chk("busy_span", 32'(busy_bad), 32'd0);
      chk("done_id", 32'(bus.done_id), 32'(id));
      chk("dec_out", bus.dec_out, exp);
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 32'd0);
   endtask

   task automatic run_until(input int n, input bit drop, input int budget);
      int got;
      int low;
      bit started;
      got = 0;
      low = 0;
      started = 1'b0;
      dbl = 0;
      ids.delete();
      vals.delete();
      gaps.delete();
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         if ($countones(bus.ack) > 1) dbl++;
         if (bus.ack != '0) started = 1'b1;
         if (drop) bus.req = bus.req & ~bus.ack;
         if (started) begin
            if (!bus.busy) low++;
            else if (low > 0) begin
               gaps.push_back(low);
               low = 0;
            end
         end
         if (bus.done) begin
            ids.push_back(int'(bus.done_id));
            vals.push_back(bus.dec_out);
            got++;
         end
      end
      chk("done_count", 32'(got), 32'(n));
   endtask

   initial begin
      int seen;
      int gap_bad;
      tbl[0] = '{0, 16'hFFFF, 32'h00065535};
      tbl[1] = '{1, 16'h0000, 32'h00000000};
      tbl[2] = '{2, 16'h8000, 32'h00032768};
      tbl[3] = '{3, 16'h1234, 32'h00004660};
      tbl[4] = '{0, 16'h00FF, 32'h00000255};
      tbl[5] = '{1, 16'h0001, 32'h00000001};
      tbl[6] = '{2, 16'h270F, 32'h00009999};
      tbl[7] = '{3, 16'h2710, 32'h00010000};
      tbl[8] = '{0, 16'h0063, 32'h00000099};
      tbl[9] = '{2, 16'hABCD, 32'h00043981};

      rst = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_done_id", 32'(bus.done_id), 32'd0);
      chk("rst_dec_out", bus.dec_out, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) run_single(tbl[i].id, tbl[i].op, tbl[i].exp);

      // Two simultaneous requesters from a fresh pointer.
      do_reset();
      bus.req_data[0*IN_W +: IN_W] = 16'h1234;
      bus.req_data[2*IN_W +: IN_W] = 16'h00FF;
      bus.req = 4'b0101;
      run_until(2, 1'b1, 2*18 + 40);
      chk("sim_dbl_ack", 32'(dbl), 32'd0);
      if (ids.size() == 2) begin
         chk("sim_id0", 32'(ids[0]), 32'd0);
         chk("sim_val0", vals[0], 32'h00004660);
         chk("sim_id1", 32'(ids[1]), 32'd2);
         chk("sim_val1", vals[1], 32'h00000255);
      end

      // All four held: strict rotation, one idle cycle between jobs.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         bus.req_data[i*IN_W +: IN_W] = 16'(10 * (i + 1));
      bus.req = 4'b1111;
      run_until(8, 1'b0, 8*18 + 40);
      bus.req = '0;
      chk("rr_dbl_ack", 32'(dbl), 32'd0);
      if (ids.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("rr_id", 32'(ids[i]), 32'(i % 4));
            chk("rr_val", vals[i], 32'((i % 4) + 1) << 4);
         end
      end
      chk("rr_gap_count", 32'(gaps.size()), 32'd7);
      gap_bad = 0;
      foreach (gaps[i]) if (gaps[i] != 1) gap_bad++;
      chk("rr_gap_len", 32'(gap_bad), 32'd0);

      // Reset pulse while shifting with count at 7.
      bus.req_data[3*IN_W +: IN_W] = 16'hABCD;
      bus.req[3] = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.ack != '0) break;
      end
      chk("abort_ack", 32'(bus.ack), 32'b1000);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (bus.done) seen++;
      rst = 1'b0;
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_ack0", 32'(bus.ack), 32'd0);
      chk("abort_busy0", 32'(bus.busy), 32'd0);
      chk("abort_dec0", bus.dec_out, 32'd0);
      chk("abort_id0", 32'(bus.done_id), 32'd0);
      run_until(1, 1'b1, 40);
      if (ids.size() == 1) begin
         chk("regrant_id", 32'(ids[0]), 32'd3);
         chk("regrant_val", vals[0], 32'h00043981);
      end

      // One-cycle req[1] while busy is never granted.
      bus.req_data[0*IN_W +: IN_W] = 16'h0063;
      bus.req[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.ack != '0) break;
      end
      bus.req[0] = 1'b0;
      repeat (3) @(negedge clk);
      bus.req_data[1*IN_W +: IN_W] = 16'h1111;
      bus.req[1] = 1'b1;
      @(negedge clk);
      bus.req[1] = 1'b0;
      run_until(1, 1'b1, 40);
      if (ids.size() == 1) begin
         chk("pulse_id", 32'(ids[0]), 32'd0);
         chk("pulse_val", vals[0], 32'h00000099);
      end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ack[1] || bus.done) seen++;
      end
      chk("pulse_no_ack", 32'(seen), 32'd0);
      chk("pulse_hold", bus.dec_out, 32'h00000099);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
